// File: rtl/fft_fp_pkg.sv
// fft_fp_pkg: shared types and elaboration helpers for the fft_fp engine.
//   cplx_t    - packed complex sample (signed re/im, CPLX_W bits each)
//   state_e   - engine FSM states
//   tw_int_t  - integer-valued twiddle pair used while building the ROM
//   bitrev()  - bit-reversal of an index over a given number of bits
//   twiddle() - rounded exp(-j*2*pi*k/ns) in Q1.(tw_w-2), evaluated at elaboration
package fft_fp_pkg;

  localparam int unsigned CPLX_W = 18;

  typedef struct packed {
    logic signed [CPLX_W-1:0] re;
    logic signed [CPLX_W-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMPUTE,
    UNLOAD
  } state_e;

  typedef struct packed {
    int re;
    int im;
  } tw_int_t;

  function automatic int unsigned bitrev(input int unsigned k, input int unsigned bits);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < bits; i++) begin
      r = r | (((k >> i) & 1) << (bits - 1 - i));
    end
    return r;
  endfunction

  // Forward twiddle only; the inverse conjugates the imaginary part at run time.
  function automatic tw_int_t twiddle(input int k, input int ns, input int tw_w);
    real     theta;
    real     scale;
    tw_int_t w;
    theta = 2.0 * 3.14159265358979323846 * real'(k) / real'(ns);
    scale = real'(1 << (tw_w - 2));
    w.re  = $rtoi($floor($cos(theta) * scale + 0.5));
    w.im  = $rtoi($floor(-$sin(theta) * scale + 0.5));
    return w;
  endfunction

endpackage

// File: rtl/fft_fp_butterfly.sv
// fft_fp_butterfly: combinational radix-2 DIT butterfly.
//   a_i, b_i          complex inputs
//   tw_re_i, tw_im_i  twiddle W, signed Q1.(TW_W-2)
//   inverse_i         1 = halve each output with round-half-up
//   a_o = a + W*b, b_o = a - W*b
// Build option: FFT_FP_SAT_EN defined -> outputs saturate to the CPLX_W signed
// range; otherwise they wrap in two's complement.
module fft_fp_butterfly
  import fft_fp_pkg::*;
#(
  parameter int unsigned TW_W = 16
) (
  input  cplx_t                   a_i,
  input  cplx_t                   b_i,
  input  logic signed [TW_W-1:0]  tw_re_i,
  input  logic signed [TW_W-1:0]  tw_im_i,
  input  logic                    inverse_i,
  output cplx_t                   a_o,
  output cplx_t                   b_o
);

  localparam int unsigned PW = CPLX_W + TW_W + 1;
  localparam int unsigned SW = CPLX_W + 4;
  localparam logic signed [PW-1:0] P_RND = PW'(1) << (TW_W - 3);
  localparam logic signed [SW-1:0] S_ONE = SW'(1);
  localparam logic signed [SW-1:0] S_MAX = SW'((1 << (CPLX_W - 1)) - 1);
  localparam logic signed [SW-1:0] S_MIN = -S_MAX - S_ONE;

  function automatic logic signed [CPLX_W-1:0] fit(input logic signed [SW-1:0] v);
`ifdef FFT_FP_SAT_EN
    if (v > S_MAX) return S_MAX[CPLX_W-1:0];
    else if (v < S_MIN) return S_MIN[CPLX_W-1:0];
    else return CPLX_W'(v);
`else
    return CPLX_W'(v);
`endif
  endfunction

  function automatic logic signed [SW-1:0] scale(input logic signed [SW-1:0] v, input logic inv);
    return inv ? ((v + S_ONE) >>> 1) : v;
  endfunction

  logic signed [PW-1:0] br_x, bi_x, wr_x, wi_x, tr_p, ti_p;
  logic signed [SW-1:0] tr, ti, ar_x, ai_x;

  always_comb begin
    br_x = PW'($signed(b_i.re));
    bi_x = PW'($signed(b_i.im));
    wr_x = PW'(tw_re_i);
    wi_x = PW'(tw_im_i);
    tr_p = br_x * wr_x - bi_x * wi_x + P_RND;
    ti_p = br_x * wi_x + bi_x * wr_x + P_RND;
    tr   = SW'(tr_p >>> (TW_W - 2));
    ti   = SW'(ti_p >>> (TW_W - 2));
    ar_x = SW'($signed(a_i.re));
    ai_x = SW'($signed(a_i.im));
    a_o.re = fit(scale(ar_x + tr, inverse_i));
    a_o.im = fit(scale(ai_x + ti, inverse_i));
    b_o.re = fit(scale(ar_x - tr, inverse_i));
    b_o.im = fit(scale(ai_x - ti, inverse_i));
  end

endmodule

// File: rtl/fft_fp.sv
// fft_fp: iterative in-place radix-2 DIT complex FFT/IFFT, NS points.
//   clk, rst_n            clock, asynchronous active-low reset
//   start, inverse        begin a transform from IDLE; inverse sampled with start
//   in_valid/in_ready     input stream, in_re/in_im natural order 0..NS-1
//   out_valid/out_ready   output stream, out_re/out_im natural order, out_last on NS-1
//   busy                  high whenever not IDLE
// Samples are stored bit-reversed on load, then LOG2_NS stages of NS/2
// butterflies (one per cycle) run in place; results are read out in order.
// Build option: FFT_FP_SAT_EN (see fft_fp_butterfly) selects saturation.
module fft_fp
  import fft_fp_pkg::*;
#(
  parameter int unsigned LOG2_NS = 3,
  parameter int unsigned NS      = 8,
  parameter int unsigned DATA_W  = 18,
  parameter int unsigned FRAC_W  = 12,
  parameter int unsigned TW_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     inverse,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_re,
  output logic signed [DATA_W-1:0] out_im,
  output logic                     out_last,
  output logic                     busy
);

  if (NS != (1 << LOG2_NS)) begin : g_ns_chk
    $error("fft_fp: NS must equal 2**LOG2_NS");
  end
  if (LOG2_NS < 2 || LOG2_NS > 10) begin : g_log_chk
    $error("fft_fp: LOG2_NS must be in 2..10");
  end
  if (DATA_W != CPLX_W || FRAC_W >= DATA_W) begin : g_w_chk
    $error("fft_fp: DATA_W must match fft_fp_pkg::CPLX_W and exceed FRAC_W");
  end

  localparam int unsigned HALF  = NS / 2;
  localparam int unsigned STG_W = (LOG2_NS > 1) ? $clog2(LOG2_NS) : 1;
  localparam logic [LOG2_NS-1:0] IDX_LAST = LOG2_NS'(NS - 1);
  localparam logic [LOG2_NS-2:0] BF_LAST  = (LOG2_NS - 1)'(HALF - 1);
  localparam logic [STG_W-1:0]   STG_LAST = STG_W'(LOG2_NS - 1);

  state_e              state_q, state_d;
  logic                inv_q, inv_d;
  logic [LOG2_NS-1:0]  cnt_q, cnt_d;
  logic [LOG2_NS-2:0]  bfly_q, bfly_d;
  logic [STG_W-1:0]    stage_q, stage_d;
  cplx_t               mem_q [NS];
  cplx_t               mem_d [NS];

  logic signed [TW_W-1:0] tw_re_tab [HALF];
  logic signed [TW_W-1:0] tw_im_tab [HALF];

  for (genvar k = 0; k < HALF; k++) begin : g_tw
    localparam tw_int_t W = twiddle(k, NS, TW_W);
    assign tw_re_tab[k] = W.re[TW_W-1:0];
    assign tw_im_tab[k] = W.im[TW_W-1:0];
  end

  // Butterfly j of stage s: group = j >> s, pos = j mod 2**s,
  // a = group*2**(s+1) + pos, b = a + 2**s, twiddle k = pos * NS/2**(s+1).
  logic [LOG2_NS-1:0]     span, pos_mask, bfly_x, a_addr, b_addr, wr_addr;
  logic [LOG2_NS-2:0]     tw_idx;
  logic signed [TW_W-1:0] tw_re, tw_im;
  cplx_t                  bf_a, bf_b;

  always_comb begin
    span     = LOG2_NS'(1) << stage_q;
    pos_mask = span - LOG2_NS'(1);
    bfly_x   = LOG2_NS'(bfly_q);
    a_addr   = ((bfly_x & ~pos_mask) << 1) | (bfly_x & pos_mask);
    b_addr   = a_addr | span;
    tw_idx   = (LOG2_NS - 1)'((bfly_x & pos_mask) << (STG_LAST - stage_q));
    tw_re    = tw_re_tab[tw_idx];
    tw_im    = inv_q ? -tw_im_tab[tw_idx] : tw_im_tab[tw_idx];
    wr_addr  = LOG2_NS'(bitrev(32'(cnt_q), LOG2_NS));
  end

  fft_fp_butterfly #(
    .TW_W (TW_W)
  ) u_bfly (
    .a_i       (mem_q[a_addr]),
    .b_i       (mem_q[b_addr]),
    .tw_re_i   (tw_re),
    .tw_im_i   (tw_im),
    .inverse_i (inv_q),
    .a_o       (bf_a),
    .b_o       (bf_b)
  );

  always_comb begin
    state_d = state_q;
    inv_d   = inv_q;
    cnt_d   = cnt_q;
    bfly_d  = bfly_q;
    stage_d = stage_q;
    mem_d   = mem_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          inv_d   = inverse;
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (in_valid) begin
          mem_d[wr_addr] = '{re: in_re, im: in_im};
          if (cnt_q == IDX_LAST) begin
            cnt_d   = '0;
            bfly_d  = '0;
            stage_d = '0;
            state_d = COMPUTE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      COMPUTE: begin
        mem_d[a_addr] = bf_a;
        mem_d[b_addr] = bf_b;
        if (bfly_q == BF_LAST) begin
          bfly_d = '0;
          if (stage_q == STG_LAST) begin
            cnt_d   = '0;
            state_d = UNLOAD;
          end else begin
            stage_d = stage_q + 1'b1;
          end
        end else begin
          bfly_d = bfly_q + 1'b1;
        end
      end
      UNLOAD: begin
        if (out_ready) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == IDX_LAST) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      inv_q   <= 1'b0;
      cnt_q   <= '0;
      bfly_q  <= '0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      inv_q   <= inv_d;
      cnt_q   <= cnt_d;
      bfly_q  <= bfly_d;
      stage_q <= stage_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    busy      = (state_q != IDLE);
    in_ready  = (state_q == LOAD);
    out_valid = (state_q == UNLOAD);
    out_last  = out_valid && (cnt_q == IDX_LAST);
    out_re    = out_valid ? mem_q[cnt_q].re : '0;
    out_im    = out_valid ? mem_q[cnt_q].im : '0;
  end

endmodule

// File: tb/tb_fft_fp.sv
// tb_fft_fp: directed self-checking bench for fft_fp (8 points, default widths).
module tb_fft_fp;

  localparam int LOG2_NS = 3;
  localparam int NS      = 8;
  localparam int DATA_W  = 18;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic inverse = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, out_last, busy;
  logic signed [DATA_W-1:0] in_re = '0;
  logic signed [DATA_W-1:0] in_im = '0;
  logic signed [DATA_W-1:0] out_re, out_im;

  int vin_re [NS];
  int vin_im [NS];
  int res_re [NS];
  int res_im [NS];
  int res_last [NS];
  int n_got;
  int n_vec = 0;
  int n_err = 0;

  int box_re [NS] = '{16384, 4096, 0, 4096, 0, 4096, 0, 4096};
  int box_im [NS] = '{0, -9889, 0, -1697, 0, 1697, 0, 9889};
  int sq_re  [NS] = '{4096, 4096, 4096, 4096, 0, 0, 0, 0};
  int imp_re [NS] = '{4096, 4096, 4096, 4096, 4096, 4096, 4096, 4096};
  int zero8  [NS] = '{0, 0, 0, 0, 0, 0, 0, 0};

  always #5 clk = ~clk;

  fft_fp #(
    .LOG2_NS (LOG2_NS),
    .NS      (NS),
    .DATA_W  (DATA_W),
    .FRAC_W  (12),
    .TW_W    (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .inverse   (inverse),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_last  (out_last),
    .busy      (busy)
  );

  task automatic check_val(input string tag, input int got, input int exp, input int tol);
    n_vec++;
    if (got > exp + tol || got < exp - tol) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  task automatic set_input(input int re [NS], input int im [NS]);
    for (int k = 0; k < NS; k++) begin
      vin_re[k] = re[k];
      vin_im[k] = im[k];
    end
  endtask

  // Starts a transform and streams vin_* in; returns at the first COMPUTE negedge.
  task automatic load_frame(input bit inv, input bit gaps, input bit poke);
    int guard;
    @(negedge clk);
    start = 1'b1;
    inverse = inv;
    @(negedge clk);
    start = 1'b0;
    inverse = 1'b0;
    for (int k = 0; k < NS; k++) begin
      if (gaps && (k % 3 == 1)) begin
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
      end
      guard = 0;
      while (!in_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      in_valid = 1'b1;
      in_re = DATA_W'(vin_re[k]);
      in_im = DATA_W'(vin_im[k]);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_re = '0;
    in_im = '0;
    if (poke) begin
      start = 1'b1;
      inverse = ~inv;
      @(negedge clk);
      start = 1'b0;
      inverse = 1'b0;
      check_val("busy during compute", int'(busy), 1, 0);
    end
  endtask

  task automatic unload_frame(input bit bp, input bit poke);
    int guard;
    bit rdy;
    guard = 0;
    while (!out_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_val("out_valid arrives", int'(out_valid), 1, 0);
    n_got = 0;
    guard = 0;
    rdy = 1'b1;
    while (n_got < NS && guard < 200) begin
      if (bp) rdy = ~rdy;
      out_ready = rdy;
      start = (poke && n_got == 3);
      if (out_valid && rdy) begin
        res_re[n_got] = int'(out_re);
        res_im[n_got] = int'(out_im);
        res_last[n_got] = int'(out_last);
        n_got++;
      end
      @(negedge clk);
      guard++;
    end
    out_ready = 1'b0;
    start = 1'b0;
    check_val("beat count", n_got, NS, 0);
    check_val("busy after unload", int'(busy), 0, 0);
    check_val("out_valid after unload", int'(out_valid), 0, 0);
  endtask

  task automatic check_result(input string name, input int er [NS], input int ei [NS],
                              input int tol);
    for (int k = 0; k < NS; k++) begin
      check_val($sformatf("%s[%0d].re", name, k), res_re[k], er[k], tol);
      check_val($sformatf("%s[%0d].im", name, k), res_im[k], ei[k], tol);
      check_val($sformatf("%s[%0d].last", name, k), res_last[k], (k == NS - 1) ? 1 : 0, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got %0d beats", n_got);
    $fatal(1, "tb_fft_fp timeout");
  end

  initial begin
    int imp_in [NS];
    int sat_in [NS];
    for (int k = 0; k < NS; k++) begin
      imp_in[k] = (k == 0) ? 4096 : 0;
      sat_in[k] = 131071;
    end

    repeat (3) @(negedge clk);
    check_val("reset busy", int'(busy), 0, 0);
    check_val("reset in_ready", int'(in_ready), 0, 0);
    check_val("reset out_valid", int'(out_valid), 0, 0);
    check_val("reset out_last", int'(out_last), 0, 0);
    check_val("reset out_re", int'(out_re), 0, 0);
    check_val("reset out_im", int'(out_im), 0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Forward of a half-on box.
    set_input(sq_re, zero8);
    load_frame(1'b0, 1'b0, 1'b0);
    unload_frame(1'b0, 1'b0);
    check_result("fwd", box_re, box_im, 6);

    // Inverse of the ideal spectrum returns the box.
    set_input(box_re, box_im);
    load_frame(1'b1, 1'b0, 1'b0);
    unload_frame(1'b0, 1'b0);
    check_result("inv", sq_re, zero8, 6);

    // Impulse: flat spectrum, exact.
    set_input(imp_in, zero8);
    load_frame(1'b0, 1'b0, 1'b0);
    unload_frame(1'b0, 1'b0);
    check_result("imp", imp_re, zero8, 0);

    // Input gaps, output backpressure, and start pulses while busy.
    set_input(sq_re, zero8);
    load_frame(1'b0, 1'b1, 1'b1);
    unload_frame(1'b1, 1'b1);
    check_result("bp", box_re, box_im, 6);

    // Reset in the middle of COMPUTE.
    set_input(sq_re, zero8);
    load_frame(1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check_val("busy before reset", int'(busy), 1, 0);
    #2 rst_n = 1'b0;
    #1;
    check_val("busy in reset", int'(busy), 0, 0);
    check_val("out_valid in reset", int'(out_valid), 0, 0);
    check_val("in_ready in reset", int'(in_ready), 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    set_input(imp_in, zero8);
    load_frame(1'b0, 1'b0, 1'b0);
    unload_frame(1'b0, 1'b0);
    check_result("rst_imp", imp_re, zero8, 0);

    // Full-scale DC: saturates to max, or wraps to -8 through three stages.
    set_input(sat_in, zero8);
    load_frame(1'b0, 1'b0, 1'b0);
    unload_frame(1'b0, 1'b0);
`ifdef FFT_FP_SAT_EN
    check_val("dc_fs X0.re", res_re[0], 131071, 0);
`else
    check_val("dc_fs X0.re", res_re[0], -8, 0);
`endif
    check_val("dc_fs X0.im", res_im[0], 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fft_fp.md
Name: fft_fp

Overview:
- Iterative in-place radix-2 decimation-in-time complex FFT/IFFT engine, NS points, fixed-point.
- Streams NS samples in, computes with one pipelined-free butterfly, streams NS results out in natural order.
- Sits between sample buffers and spectral processing; one transform in flight at a time.

Parameters:
- LOG2_NS, 3, log2 of transform size (2..10).
- NS, 8, points per transform; must equal 2**LOG2_NS (elaboration error otherwise).
- DATA_W, 18, signed width of each real/imag component.
- FRAC_W, 12, fractional bits (1.0 = 4096 at default).
- TW_W, 16, signed twiddle width, Q1.(TW_W-2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a transform (accepted only in IDLE).
- inverse  in  1  sampled with start; 1 = inverse transform.
- in_valid  in  1  input sample valid.
- in_ready  out  1  high in LOAD.
- in_re, in_im  in  DATA_W each  input sample, natural order index 0..NS-1.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts.
- out_re, out_im  out  DATA_W each  result sample, natural order.
- out_last  out  1  high with sample NS-1.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset: state IDLE; in_ready, out_valid, out_last, busy = 0; out_re/out_im = 0; sample memory contents don't-care.
- IDLE: start=1 latches inverse, goes LOAD next cycle. start outside IDLE ignored.
- LOAD: in_ready=1; each in_valid&in_ready beat writes sample k to address bitrev(k). After NS beats -> COMPUTE.
- COMPUTE: LOG2_NS stages, stage s span 2**s. One butterfly per cycle, exactly LOG2_NS*NS/2 cycles. Butterfly: t = W*b; a' = a+t; b' = a-t.
- Twiddle W = exp(-j*2*pi*k/NS) forward, conjugate for inverse. Twiddles are rounded to TW_W bits.
- Product rounding: round-half-up, i.e. add 2**(TW_W-3), then arithmetic shift by TW_W-2.
- Forward: no scaling.
- Inverse: each butterfly output arithmetic-shifted right by 1 with round-half-up, giving total 1/NS scaling. forward then inverse returns the input within tolerance.
- Then UNLOAD.
- UNLOAD: out_valid=1, sample index 0..NS-1 presented in order. Index advances only on out_valid&out_ready; out_last on index NS-1. After final beat -> IDLE same edge.
- Overflow: see optional feature.
- rst_n low mid-operation: immediate return to IDLE, all outputs to reset values; partial data discarded.
- Accuracy: each output within ±(2*LOG2_NS) LSB of the ideal double-precision result.

Optional Feature:
- FFT_FP_SAT_EN defined: butterfly sums/differences saturate to the DATA_W signed range.
- Not defined: two's-complement wrap.

Decomposition:
- Package fft_fp_pkg:
  - complex struct typedef (re, im signed DATA_W);
  - bitrev function;
  - elaboration-time twiddle table function built from $cos/$sin over NS/2 entries;
  - state enum (IDLE, LOAD, COMPUTE, UNLOAD).
- Sub-module fft_fp_butterfly: combinational complex multiply, add/sub, inverse shift, saturation.

Test Plan:
- Reset, then forward. Stimulus: x = [1,1,1,1,0,0,0,0] (re=4096, im=0). Expected X:
  - (16384,0), (4096,-9889), (0,0), (4096,-1697), (0,0), (4096,1697), (0,0), (4096,9889), all ±6 LSB.
  - out_last on the 8th beat.
- Inverse of that X -> [4096 x4, 0 x4] imag 0, ±6 LSB.
- Impulse x[0]=4096, others 0, forward -> all 8 outputs (4096,0).
- Backpressure: toggle out_ready every other cycle and gaps in in_valid -> identical results, no lost or duplicated samples; start during busy ignored.
- Assert rst_n low during COMPUTE -> busy/out_valid drop immediately. A subsequent transform of the impulse gives the correct result.
- With FFT_FP_SAT_EN: forward of x all (131071,0) -> X[0]=(131071,0) saturated; without the macro, wrapped value.
